inst_fetch_unit: RTL and testbench

//   Front end of the 5-stage pipeline: owns the PC, issues in-order instruction fetches to imem,

---
 rtl/inst_fetch_unit_pkg.sv | 13 +
 rtl/inst_fetch_unit_fetch_fifo.sv | 49 ++++
 rtl/inst_fetch_unit.sv | 120 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end.
// INST_NOP is the bubble word IF_ID inserts when out_valid is low.
package inst_fetch_unit_pkg;

    localparam int DATA_LEN_DEFAULT        = 32;
    localparam int INST_LEN_DEFAULT        = 32;
    localparam int DEPTH_DEFAULT           = 4;
    localparam int MAX_OUTSTANDING_DEFAULT = 2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} fetch entries between imem and IF_ID.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the empty mask keeps stale words off dout.
    always_ff @(posedge clk) begin
        if (reset && !flush && push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = CW'(wr_ptr - rd_ptr);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the PC, issues in-order imem requests under a FIFO credit
// limit, buffers returned words and presents {pc, inst} to IF_ID; EX redirects flush it.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                    DATA_LEN        = DATA_LEN_DEFAULT,
    parameter int                    INST_LEN        = INST_LEN_DEFAULT,
    parameter int                    DEPTH           = DEPTH_DEFAULT,
    parameter int                    MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter logic [DATA_LEN-1:0]   RESET_PC        = DATA_LEN'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [DATA_LEN-1:0]   redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_LEN-1:0]   imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_LEN-1:0]   imem_resp_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_pc,
    output logic [INST_LEN-1:0]   out_inst
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int SW = CW + OW + 1;

    logic [DATA_LEN-1:0] fetch_pc;
    logic [DATA_LEN-1:0] enq_pc;
    logic [OW-1:0]       outstanding;
    logic [OW-1:0]       discard;
    logic [OW-1:0]       outstanding_nx;
    logic [OW-1:0]       discard_nx;
    logic [CW-1:0]       count;
    logic [SW-1:0]       credit_used;
    logic [DATA_LEN-1:0] redirect_aligned;

    logic req_fire;
    logic resp_fire;
    logic drop_word;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // Words still owed to the FIFO (in flight and not to be discarded) count against its space.
    assign credit_used = SW'(count) + SW'(outstanding) - SW'(discard);

    assign imem_req_valid = reset && !redirect_valid
                            && (outstanding < OW'(MAX_OUTSTANDING))
                            && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign resp_fire  = imem_resp_valid;
    assign drop_word  = (discard != '0);
    assign push       = resp_fire && !drop_word && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign out_valid  = !fifo_empty;

    assign redirect_aligned = redirect_pc & ~DATA_LEN'(3);

    always_comb begin
        outstanding_nx = outstanding;
        discard_nx     = discard;
        if (req_fire)  outstanding_nx = outstanding_nx + OW'(1);
        if (resp_fire) outstanding_nx = outstanding_nx - OW'(1);
        if (redirect_valid) begin
            discard_nx = resp_fire ? (outstanding - OW'(1)) : outstanding;
        end else if (resp_fire && drop_word) begin
            discard_nx = discard - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            enq_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nx;
            discard     <= discard_nx;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                enq_pc   <= redirect_aligned;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + DATA_LEN'(4);
                if (push)     enq_pc   <= enq_pc + DATA_LEN'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_LEN + INST_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({enq_pc, imem_resp_inst}),
        .dout  ({out_pc, out_inst}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    a_discard_bounded: assert property (@(posedge clk) disable iff (!reset)
        discard <= outstanding);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full && !pop));
    a_resp_expected: assert property (@(posedge clk) disable iff (!reset)
        !(imem_resp_valid && outstanding == '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference of the fetch stream plus an imem model,
// compared every cycle, with directed scenarios and a randomized soak.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        fq[$];          // expected FIFO contents, head first
    req_t        iq[$];          // requests accepted by imem, in order
    logic [31:0] dut_pops[$];    // pcs the DUT handed to IF_ID
    int          m_drop = 0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_enq = '0;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  lat = 1;
    bit  resp_en = 1'b1;
    bit  rand_lat = 1'b0;
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[31:16] ^ 16'h5a5a};
    endfunction

    function automatic bit resp_due();
        return reset && resp_en && iq.size() > 0 && iq[0].due <= cyc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive imem response, compare at negedge, advance the model, return after posedge.
    task automatic cycle();
        bit   exp_req, rf, respf, popf;
        req_t r;
        int   l;
        if (resp_due()) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(iq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = 32'hdead_beef;
        end
        @(negedge clk);
        exp_req = reset && !redirect_valid && iq.size() < 2
                  && (fq.size() + iq.size() - m_drop) < 4;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
        chk("out_valid", 32'(out_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            chk("out_pc", out_pc, fq[0].pc);
            chk("out_inst", out_inst, fq[0].inst);
        end
        if (reset && out_valid && out_ready && !redirect_valid) dut_pops.push_back(out_pc);

        rf    = exp_req && imem_req_ready;
        respf = imem_resp_valid;
        popf  = fq.size() > 0 && out_ready;
        if (!reset) begin
            fq.delete(); iq.delete();
            m_drop = 0; m_fetch = 32'h0; m_enq = 32'h0;
        end else begin
            if (respf) r = iq.pop_front();
            if (redirect_valid) begin
                fq.delete();
                m_drop  = iq.size();
                m_fetch = redirect_pc & ~32'h3;
                m_enq   = redirect_pc & ~32'h3;
            end else begin
                if (popf) void'(fq.pop_front());
                if (respf) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        fq.push_back('{m_enq, inst_of(m_enq)});
                        m_enq += 32'd4;
                    end
                end
                if (rf) begin
                    l = rand_lat ? int'($urandom_range(1, 4)) : lat;
                    iq.push_back('{m_fetch, cyc + l});
                    m_fetch += 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_reset();
        reset = 1'b0; redirect_valid = 1'b0;
        run(2);
        reset = 1'b1;
    endtask

    initial begin
        int t0, first_valid, n;
        @(posedge clk);
        #1;

        // reset state
        cycle();
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_req_valid", 32'(s_req_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        reset = 1'b1;

        // straight line, 1-cycle imem, no stall
        out_ready = 1'b1; imem_req_ready = 1'b1; lat = 1; resp_en = 1'b1;
        dut_pops.delete(); t0 = cyc; first_valid = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_out_valid && first_valid < 0) first_valid = cyc - 1 - t0;
        end
        chk("t1_fill_latency", 32'(first_valid), 32'd2);
        chk("t1_npops", 32'(dut_pops.size() >= 4), 32'd1);
        if (dut_pops.size() >= 4) begin
            chk("t1_pop0", dut_pops[0], 32'h0);
            chk("t1_pop1", dut_pops[1], 32'h4);
            chk("t1_pop2", dut_pops[2], 32'h8);
            chk("t1_pop3", dut_pops[3], 32'hc);
        end

        // stall fills the FIFO, then drains in order
        pulse_reset();
        out_ready = 1'b0;
        run(10);
        chk("t2_req_blocked", 32'(s_req_valid), 32'd0);
        chk("t2_model_full", 32'(fq.size()), 32'd4);
        chk("t2_head_pc", out_pc, 32'h0);
        out_ready = 1'b1; dut_pops.delete();
        run(6);
        chk("t2_npops", 32'(dut_pops.size() >= 4), 32'd1);
        if (dut_pops.size() >= 4) begin
            chk("t2_pop0", dut_pops[0], 32'h0);
            chk("t2_pop1", dut_pops[1], 32'h4);
            chk("t2_pop2", dut_pops[2], 32'h8);
            chk("t2_pop3", dut_pops[3], 32'hc);
        end

        // redirect with pc 8 and 12 in flight
        pulse_reset();
        out_ready = 1'b1; imem_req_ready = 1'b1; resp_en = 1'b0; lat = 1;
        run(2);
        imem_req_ready = 1'b0; resp_en = 1'b1;
        run(2);
        imem_req_ready = 1'b1; resp_en = 1'b0;
        run(2);
        chk("t3_inflight", 32'(iq.size()), 32'd2);
        if (iq.size() == 2) chk("t3_head_addr", iq[0].addr, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        chk("t3_no_req_on_redirect", 32'(s_req_valid), 32'd0);
        redirect_valid = 1'b0; resp_en = 1'b1; dut_pops.delete();
        run(10);
        chk("t3_npops", 32'(dut_pops.size() >= 1), 32'd1);
        if (dut_pops.size() >= 1) chk("t3_first_pc", dut_pops[0], 32'h100);

        // redirect colliding with a response and a pop; misaligned target
        pulse_reset();
        out_ready = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b1; lat = 3;
        n = 0;
        while (!(resp_due() && fq.size() > 0 && iq.size() == 2) && n < 30) begin
            cycle();
            n++;
        end
        chk("t4_setup_found", 32'(n < 30), 32'd1);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
        cycle();
        chk("t4_pop_attempted", 32'(s_out_valid), 32'd1);
        chk("t4_model_discard", 32'(m_drop), 32'd1);
        redirect_valid = 1'b0; dut_pops.delete();
        cycle();
        chk("t4_out_valid_after", 32'(s_out_valid), 32'd0);
        run(12);
        chk("t4_npops", 32'(dut_pops.size() >= 1), 32'd1);
        if (dut_pops.size() >= 1) chk("t4_first_pc", dut_pops[0], 32'h200);

        // reset mid-stream with FIFO half full
        pulse_reset();
        out_ready = 1'b0; lat = 1; resp_en = 1'b1; imem_req_ready = 1'b1;
        n = 0;
        while (fq.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_half_full", 32'(fq.size()), 32'd2);
        reset = 1'b0;
        run(2);
        chk("t5_out_valid", 32'(s_out_valid), 32'd0);
        chk("t5_req_valid", 32'(s_req_valid), 32'd0);
        reset = 1'b1;
        cycle();
        chk("t5_req_after", 32'(s_req_valid), 32'd1);
        chk("t5_addr_after", s_req_addr, 32'h0);

        // randomized soak
        rand_lat = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            resp_en        = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 63) == 0);
            redirect_pc    = $urandom & 32'h0000_fffff;
            cycle();
        end
        redirect_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
